flash_arbiter: RTL

FLASH_ARBITER -- requirements
Module: flash_arbiter

---
 rtl/flash_arb_pkg.sv | 32 +++
 rtl/flash_guard_timer.sv | 48 ++++
 rtl/flash_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/flash_arb_pkg.sv
// ---------------------------------------------------------------------------
// flash_arb_pkg
// Shared definitions for the SPI flash pin arbiter: FSM state encoding,
// owner codes, default parameter values and the idle pin levels.
// ---------------------------------------------------------------------------
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN_ROM  = 2'd1,
        ST_OWN_PROG = 2'd2,
        ST_GUARD    = 2'd3
    } arb_state_t;

    // Owner code 2'b11 is never driven.
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_ROM  = 2'b01;
    localparam logic [1:0] OWNER_PROG = 2'b10;

    localparam int unsigned DEF_GUARD_CYCLES  = 4;
    localparam int unsigned DEF_PROG_PRIORITY = 1;

    // Guard counter width covers the legal GUARD_CYCLES range 1..255.
    localparam int unsigned GUARD_CNT_W = 8;

    // Pin levels whenever nobody owns the flash (IDLE and GUARD).
    localparam logic IDLE_CS_N = 1'b1;
    localparam logic IDLE_CLK  = 1'b0;
    localparam logic IDLE_MOSI = 1'b0;
    localparam logic IDLE_MISO = 1'b1;

endpackage : flash_arb_pkg

// File: rtl/flash_guard_timer.sv
// ---------------------------------------------------------------------------
// flash_guard_timer
// Counts the idle gap between two flash owners. A load pulse arms the
// counter with GUARD_CYCLES-1; it then decrements once per clock and raises
// o_done for exactly one cycle when it has reached zero, so the arbiter
// spends exactly GUARD_CYCLES cycles in its guard state.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (counter cleared)
//   i_load  in  arm the counter (asserted on the edge that enters GUARD)
//   o_done  out single-cycle pulse: guard interval complete
// ---------------------------------------------------------------------------
module flash_guard_timer
    import flash_arb_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam logic [GUARD_CNT_W-1:0] LOAD_VAL = GUARD_CNT_W'(GUARD_CYCLES - 1);

    logic [GUARD_CNT_W-1:0] r_count;
    logic                   r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_count  <= LOAD_VAL;
            r_active <= 1'b1;
        end else if (r_count != '0) begin
            r_count  <= r_count - 1'b1;
        end else begin
            r_active <= 1'b0;
        end
    end

    // r_active keeps the done pulse to the single cycle after the count
    // reaches zero; an idle counter sitting at zero does not report done.
    assign o_done = r_active && (r_count == '0);

endmodule : flash_guard_timer

// File: rtl/flash_arbiter.sv
// ---------------------------------------------------------------------------
// flash_arbiter
// Shares one SPI flash between the ROM fetch controller and the UART flash
// programmer. A registered FSM (IDLE / OWN_ROM / OWN_PROG / GUARD) grants
// ownership; while a requester owns the flash its SPI drive is passed
// straight through to the pins. Ownership changes always pass through a
// GUARD interval of GUARD_CYCLES idle pin cycles.
//
// Parameters:
//   GUARD_CYCLES   idle cycles between owners (1..255)
//   PROG_PRIORITY  1: programmer wins ties and may preempt the ROM fetcher
//                  0: ROM fetcher wins ties and may preempt the programmer
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   rom_req  / rom_gnt                ROM fetcher request / grant
//   rom_spi_clk/mosi/cs_n, rom_spi_miso    ROM fetcher SPI drive / readback
//   prog_req / prog_gnt               programmer request / grant
//   prog_spi_clk/mosi/cs_n, prog_spi_miso  programmer SPI drive / readback
//   flash_clk/mosi/cs_n, flash_miso   physical flash pins
//   busy                              high in any state except IDLE
//   owner                             00 none, 01 ROM, 10 programmer
// ---------------------------------------------------------------------------
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES  = DEF_GUARD_CYCLES,
    parameter int unsigned PROG_PRIORITY = DEF_PROG_PRIORITY
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       rom_req,
    output logic       rom_gnt,
    input  logic       rom_spi_clk,
    input  logic       rom_spi_mosi,
    input  logic       rom_spi_cs_n,
    output logic       rom_spi_miso,

    input  logic       prog_req,
    output logic       prog_gnt,
    input  logic       prog_spi_clk,
    input  logic       prog_spi_mosi,
    input  logic       prog_spi_cs_n,
    output logic       prog_spi_miso,

    output logic       flash_clk,
    output logic       flash_mosi,
    output logic       flash_cs_n,
    input  logic       flash_miso,

    output logic       busy,
    output logic [1:0] owner
);

    localparam bit PROG_WINS = (PROG_PRIORITY != 0);

    arb_state_t r_state;
    logic       r_rom_gnt;
    logic       r_prog_gnt;
    logic       r_busy;
    logic [1:0] r_owner;

    logic w_prog_first;
    logic w_rom_leave;
    logic w_prog_leave;
    logic w_guard_load;
    logic w_guard_done;

    // A tie in IDLE goes to the higher-priority requester.
    assign w_prog_first = prog_req && (PROG_WINS || !rom_req);

    // An owner leaves only while its chip select is high, so a flash
    // command is never cut: either it released its request, or the
    // higher-priority requester is waiting.
    assign w_rom_leave  = rom_spi_cs_n  && (!rom_req  || ( PROG_WINS && prog_req));
    assign w_prog_leave = prog_spi_cs_n && (!prog_req || (!PROG_WINS && rom_req));

    assign w_guard_load = ((r_state == ST_OWN_ROM)  && w_rom_leave) ||
                          ((r_state == ST_OWN_PROG) && w_prog_leave);

    flash_guard_timer #(
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_guard (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_guard_load),
        .o_done (w_guard_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rom_gnt  <= 1'b0;
            r_prog_gnt <= 1'b0;
            r_owner    <= OWNER_NONE;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_prog_first) begin
                        r_state    <= ST_OWN_PROG;
                        r_prog_gnt <= 1'b1;
                        r_owner    <= OWNER_PROG;
                        r_busy     <= 1'b1;
                    end else if (rom_req) begin
                        r_state   <= ST_OWN_ROM;
                        r_rom_gnt <= 1'b1;
                        r_owner   <= OWNER_ROM;
                        r_busy    <= 1'b1;
                    end
                end
                ST_OWN_ROM: begin
                    if (w_rom_leave) begin
                        r_state   <= ST_GUARD;
                        r_rom_gnt <= 1'b0;
                        r_owner   <= OWNER_NONE;
                    end
                end
                ST_OWN_PROG: begin
                    if (w_prog_leave) begin
                        r_state    <= ST_GUARD;
                        r_prog_gnt <= 1'b0;
                        r_owner    <= OWNER_NONE;
                    end
                end
                ST_GUARD: begin
                    if (w_guard_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rom_gnt  <= 1'b0;
                    r_prog_gnt <= 1'b0;
                    r_owner    <= OWNER_NONE;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign rom_gnt  = r_rom_gnt;
    assign prog_gnt = r_prog_gnt;
    assign owner    = r_owner;
    assign busy     = r_busy;

    // Pin mux keys off the registered state: the cycle a grant falls the
    // pins are already idle, which masks any late chip-select drop from the
    // requester that just lost ownership. Reset forces IDLE asynchronously,
    // so the pins go idle without waiting for a clock.
    always_comb begin
        flash_cs_n    = IDLE_CS_N;
        flash_clk     = IDLE_CLK;
        flash_mosi    = IDLE_MOSI;
        rom_spi_miso  = IDLE_MISO;
        prog_spi_miso = IDLE_MISO;
        case (r_state)
            ST_OWN_ROM: begin
                flash_cs_n   = rom_spi_cs_n;
                flash_clk    = rom_spi_clk;
                flash_mosi   = rom_spi_mosi;
                rom_spi_miso = flash_miso;
            end
            ST_OWN_PROG: begin
                flash_cs_n    = prog_spi_cs_n;
                flash_clk     = prog_spi_clk;
                flash_mosi    = prog_spi_mosi;
                prog_spi_miso = flash_miso;
            end
            default: ;
        endcase
    end

endmodule : flash_arbiter
